// File: rtl/escritor_memoria.sv
// Write-side controller for the data memory: buffers datapath writes in a small FIFO,
// drains one per cycle onto the memory port, and optionally sweeps memory after reset.
module escritor_memoria #(
  parameter int unsigned       DATA_W         = 32,
  parameter int unsigned       ADDR_W         = 5,
  parameter int unsigned       FIFO_DEPTH     = 4,
  parameter bit                CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [DATA_W-1:0]             req_data,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_data,
  input  logic [ADDR_W-1:0]             lkp_addr,
  output logic                          lkp_hit,
  output logic [DATA_W-1:0]             lkp_data,
  output logic                          init_done,
  output logic [$clog2(FIFO_DEPTH):0]   pending
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_DRAIN
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] sweep_cnt, sweep_cnt_nxt;
  logic              mem_we_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_data_nxt;
  logic              init_done_nxt;
  logic              req_ready_nxt;

  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, count_nxt;
  logic              push, pop;
  logic [PTR_W-1:0]  lkp_idx;

  assign push    = req_valid && req_ready;
  assign pop     = (state != ST_CLEAR) && (count != '0);
  assign pending = count;

  always_comb begin
    unique case ({push, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // FIFO payload storage; contents are only meaningful under count
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= req_addr;
      fifo_data[wr_ptr] <= req_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
    end
  end

  // State register and registered memory-port outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      sweep_cnt <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      init_done <= 1'b0;
      req_ready <= 1'b0;
    end else begin
      state     <= state_nxt;
      sweep_cnt <= sweep_cnt_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_data  <= mem_data_nxt;
      init_done <= init_done_nxt;
      req_ready <= req_ready_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    sweep_cnt_nxt = sweep_cnt;
    mem_we_nxt    = 1'b0;
    mem_addr_nxt  = mem_addr;
    mem_data_nxt  = mem_data;
    init_done_nxt = init_done;

    unique case (state)
      ST_CLEAR: begin
        mem_we_nxt    = 1'b1;
        mem_addr_nxt  = sweep_cnt;
        mem_data_nxt  = CLEAR_VALUE;
        sweep_cnt_nxt = sweep_cnt + ADDR_W'(1);
        if (sweep_cnt == '1) begin
          state_nxt     = ST_IDLE;
          init_done_nxt = 1'b1;
        end
      end
      ST_IDLE, ST_DRAIN: begin
        init_done_nxt = 1'b1;
        if (pop) begin
          mem_we_nxt   = 1'b1;
          mem_addr_nxt = fifo_addr[rd_ptr];
          mem_data_nxt = fifo_data[rd_ptr];
        end
        state_nxt = ((count_nxt != '0) || mem_we_nxt) ? ST_DRAIN : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Registered ready reflects the occupancy after this edge; no full-FIFO bypass
    req_ready_nxt = init_done_nxt && (count_nxt < CNT_W'(FIFO_DEPTH));
  end

  // Lookup scans oldest to youngest so the youngest match overrides
  always_comb begin
    lkp_hit  = 1'b0;
    lkp_data = '0;
    lkp_idx  = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      lkp_idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (fifo_addr[lkp_idx] == lkp_addr)) begin
        lkp_hit  = 1'b1;
        lkp_data = fifo_data[lkp_idx];
      end
    end
  end

endmodule

// File: tb/tb_escritor_memoria.sv
// Bench for escritor_memoria: expected memory writes go into a queue, a negedge monitor
// pops and compares every mem_we cycle; directed checks cover reset, latency and lookup.
module tb_escritor_memoria;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_addr;
  logic [31:0] req_data;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [31:0] mem_data;
  logic [4:0]  lkp_addr;
  logic        lkp_hit;
  logic [31:0] lkp_data;
  logic        init_done;
  logic [2:0]  pending;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks = 0;
  int  errors = 0;
  int  cycles;
  int  waits;

  escritor_memoria dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .lkp_addr  (lkp_addr),
    .lkp_hit   (lkp_hit),
    .lkp_data  (lkp_data),
    .init_done (init_done),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Drive one request and hold it until accepted; records the expected memory write
  task automatic send(input logic [4:0] a, input logic [31:0] d, output int w);
    w = 0;
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    while (!req_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: actual=ready_low required=ready_high addr=%0d", a);
      req_valid = 1'b0;
    end else begin
      exp_q.push_back('{a: a, d: d});
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: actual addr=%0d data=%h required=no write", mem_addr, mem_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (mem_addr !== mon_e.a || mem_data !== mon_e.d) begin
          errors++;
          $display("FAIL mem_write: actual addr=%0d data=%h required addr=%0d data=%h",
                   mem_addr, mem_data, mon_e.a, mon_e.d);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0; lkp_addr = '0;
    for (int i = 0; i < 32; i++) exp_q.push_back('{a: 5'(i), d: 32'h0});

    // Reset state
    repeat (3) @(posedge clk); #1;
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_data", 64'(mem_data), 64'd0);
    check("rst_pending", 64'(pending), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_init_done", 64'(init_done), 64'd0);

    // Sweep after reset release
    rst_n = 1'b1;
    cycles = 0;
    while (cycles < 100) begin
      @(posedge clk); #2;
      cycles++;
      if (init_done) break;
    end
    check("sweep_cycles", 64'(cycles), 64'd32);
    @(posedge clk); #1;
    check("post_sweep_mem_we", 64'(mem_we), 64'd0);
    check("post_sweep_ready", 64'(req_ready), 64'd1);
    check("post_sweep_init_done", 64'(init_done), 64'd1);
    check("post_sweep_queue", 64'(exp_q.size()), 64'd0);

    // Single write latency
    send(5'd5, 32'hDEADBEEF, waits);
    req_valid = 1'b0;
    check("single_pending_after_push", 64'(pending), 64'd1);
    check("single_we_before_drain", 64'(mem_we), 64'd0);
    @(posedge clk); #1;
    check("single_we", 64'(mem_we), 64'd1);
    check("single_addr", 64'(mem_addr), 64'd5);
    check("single_data", 64'(mem_data), 64'hDEADBEEF);
    check("single_pending_after_pop", 64'(pending), 64'd0);
    @(posedge clk); #1;
    check("single_we_off", 64'(mem_we), 64'd0);
    check("single_addr_hold", 64'(mem_addr), 64'd5);

    // Back-to-back requests, drained one per cycle
    for (int i = 0; i < 6; i++) begin
      check("b2b_ready", 64'(req_ready), 64'd1);
      send(5'(10 + i), 32'h1000 + 32'(i), waits);
      check("b2b_pending_le1", 64'(pending <= 3'd1), 64'd1);
    end
    req_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("b2b_drained", 64'(exp_q.size()), 64'd0);
    check("b2b_pending_zero", 64'(pending), 64'd0);

    // Lookup: youngest match, no hit on other address or on already-popped entry
    send(5'd7, 32'h11, waits);
    req_valid = 1'b0;
    lkp_addr = 5'd7; #1;
    check("lkp_first_hit", 64'(lkp_hit), 64'd1);
    check("lkp_first_data", 64'(lkp_data), 64'h11);
    send(5'd7, 32'h22, waits);
    req_valid = 1'b0;
    #1;
    check("lkp_young_hit", 64'(lkp_hit), 64'd1);
    check("lkp_young_data", 64'(lkp_data), 64'h22);
    lkp_addr = 5'd8; #1;
    check("lkp_miss_hit", 64'(lkp_hit), 64'd0);
    check("lkp_miss_data", 64'(lkp_data), 64'd0);
    lkp_addr = 5'd7;
    @(posedge clk); #1;
    check("lkp_popped_hit", 64'(lkp_hit), 64'd0);
    check("lkp_popped_data", 64'(lkp_data), 64'd0);
    @(posedge clk); #1;

    // Asynchronous reset with an entry pending, then a request held through the sweep
    send(5'd9, 32'h99, waits);
    req_valid = 1'b0;
    check("pre_reset_pending", 64'(pending), 64'd1);
    rst_n = 1'b0; #1;
    check("async_we", 64'(mem_we), 64'd0);
    check("async_pending", 64'(pending), 64'd0);
    check("async_init_done", 64'(init_done), 64'd0);
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back('{a: 5'(i), d: 32'h0});
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    send(5'd3, 32'hCAFE, waits);
    req_valid = 1'b0;
    check("held_wait_cycles", 64'(waits), 64'd32);
    repeat (4) @(posedge clk); #1;
    check("final_queue", 64'(exp_q.size()), 64'd0);
    check("final_pending", 64'(pending), 64'd0);
    check("final_init_done", 64'(init_done), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
